// File: rtl/pipelined_mac_param.sv
// Purpose    : parametrised pipelined multiply-accumulate (DSP-template target, MULT + ALU accumulate path).
// Latency    : PIPELINE_DEPTH ce-cycles from accepted input to out/out_valid.
// Backpressure: none; ce=0 stalls every register (global clock enable), one input per ce-cycle otherwise.
//
// Ports:
//   clk, rst_n        rising-edge clock, synchronous active-low reset (overrides ce)
//   ce                clock enable; 0 freezes all state including out/out_valid
//   in_valid, a, b    operands, accepted when ce=1 and in_valid=1
//   acc_en            1 = acc += a*b, 0 = acc = a*b (travels with its operands)
//   out, out_valid    accumulator low bits (or clamped value) and final-stage valid
//   sat               (only with PIPELINED_MAC_SATURATE_EN) out is currently clamped
//
// Optional feature macro: PIPELINED_MAC_SATURATE_EN -- clamp out to the OUT_WIDTH range
// instead of wrapping; the accumulator itself always wraps. Requires ACC_WIDTH > OUT_WIDTH >= 2.
module pipelined_mac_param #(
    parameter int A_WIDTH        = 8,
    parameter int B_WIDTH        = 8,
    parameter int OUT_WIDTH      = 8,
    parameter int ACC_WIDTH      = 24,
    parameter int PIPELINE_DEPTH = 2,
    parameter bit SIGNED         = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ce,
    input  logic                 in_valid,
    input  logic [A_WIDTH-1:0]   a,
    input  logic [B_WIDTH-1:0]   b,
    input  logic                 acc_en,
    output logic [OUT_WIDTH-1:0] out,
    output logic                 out_valid
`ifdef PIPELINED_MAC_SATURATE_EN
    ,
    output logic                 sat
`endif
);

    localparam int PW = A_WIDTH + B_WIDTH;

    // Full-width product extended to the accumulator width; nothing is truncated.
    logic [PW-1:0]        prod_full;
    logic [ACC_WIDTH-1:0] prod_c;

    generate
        if (SIGNED) begin : g_signed
            logic signed [PW-1:0] prod_s;
            // Sizing the signed operands to PW first sign-extends them, so the
            // low PW bits of the product are the exact two's-complement result.
            assign prod_s    = PW'($signed(a)) * PW'($signed(b));
            assign prod_full = prod_s;
            assign prod_c    = ACC_WIDTH'(prod_s);
        end else begin : g_unsigned
            assign prod_full = PW'(a) * PW'(b);
            assign prod_c    = ACC_WIDTH'(prod_full);
        end
    endgenerate

    // Signals entering the final (accumulate) stage.
    logic [ACC_WIDTH-1:0] fin_prod;
    logic                 fin_vld;
    logic                 fin_acc_en;

    generate
        if (PIPELINE_DEPTH == 1) begin : g_nopipe
            // Single-stage build: multiply and accumulate share the one register stage.
            assign fin_prod   = prod_c;
            assign fin_vld    = in_valid;
            assign fin_acc_en = acc_en;
        end else begin : g_pipe
            // Stages 1..PIPELINE_DEPTH-1 carry the registered product; the
            // accumulator register is the last stage.
            logic [ACC_WIDTH-1:0]    prod_q   [1:PIPELINE_DEPTH-1];
            logic [PIPELINE_DEPTH-1:1] vld_q;
            logic [PIPELINE_DEPTH-1:1] acc_en_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 1; i < PIPELINE_DEPTH; i++) begin
                        prod_q[i] <= '0;
                    end
                    vld_q    <= '0;
                    acc_en_q <= '0;
                end else if (ce) begin
                    prod_q[1]   <= prod_c;
                    vld_q[1]    <= in_valid;
                    acc_en_q[1] <= acc_en;
                    for (int i = 2; i < PIPELINE_DEPTH; i++) begin
                        prod_q[i]   <= prod_q[i-1];
                        vld_q[i]    <= vld_q[i-1];
                        acc_en_q[i] <= acc_en_q[i-1];
                    end
                end
            end

            assign fin_prod   = prod_q[PIPELINE_DEPTH-1];
            assign fin_vld    = vld_q[PIPELINE_DEPTH-1];
            assign fin_acc_en = acc_en_q[PIPELINE_DEPTH-1];
        end
    endgenerate

    // Accumulator stage; a bubble leaves acc untouched so out holds its value.
    logic [ACC_WIDTH-1:0] acc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc       <= '0;
            out_valid <= 1'b0;
        end else if (ce) begin
            out_valid <= fin_vld;
            if (fin_vld) begin
                acc <= fin_acc_en ? (acc + fin_prod) : fin_prod;
            end
        end
    end

`ifdef PIPELINED_MAC_SATURATE_EN
    // Clamp is purely combinational on acc, so out and sat change on the same
    // edge as acc and hold through stalls and bubbles.
    always_comb begin
        out = acc[OUT_WIDTH-1:0];
        sat = 1'b0;
        if (SIGNED) begin
            // In range only if every bit from the OUT_WIDTH sign bit upward agrees.
            if (!(&acc[ACC_WIDTH-1:OUT_WIDTH-1]) && (|acc[ACC_WIDTH-1:OUT_WIDTH-1])) begin
                sat = 1'b1;
                out = acc[ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                       : {1'b0, {(OUT_WIDTH-1){1'b1}}};
            end
        end else if (|acc[ACC_WIDTH-1:OUT_WIDTH]) begin
            sat = 1'b1;
            out = '1;
        end
    end
`else
    assign out = acc[OUT_WIDTH-1:0];
`endif

endmodule

// File: tb/tb_pipelined_mac_param.sv
module tb_pipelined_mac_param;

    typedef struct {
        logic [7:0] val;
        logic       sat;
        int         due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ce;

    // Default instance: signed, depth 2.
    logic       s_in_valid, s_acc_en, s_out_valid;
    logic [7:0] s_a, s_b, s_out;
    // Second instance: unsigned, depth 3.
    logic       u_in_valid, u_acc_en, u_out_valid;
    logic [7:0] u_a, u_b, u_out;
`ifdef PIPELINED_MAC_SATURATE_EN
    logic       s_sat, u_sat;
`endif

    exp_t q_s[$];
    exp_t q_u[$];
    int   cmp_cnt  = 0;
    int   fail_cnt = 0;
    int   ce_cnt   = 0;
    logic last_en  = 1'b0;
    logic [7:0] hold;

    always #5 clk = ~clk;

    pipelined_mac_param u_s (
        .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(s_in_valid),
        .a(s_a), .b(s_b), .acc_en(s_acc_en), .out(s_out), .out_valid(s_out_valid)
`ifdef PIPELINED_MAC_SATURATE_EN
        , .sat(s_sat)
`endif
    );

    pipelined_mac_param #(.PIPELINE_DEPTH(3), .SIGNED(1'b0)) u_u (
        .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(u_in_valid),
        .a(u_a), .b(u_b), .acc_en(u_acc_en), .out(u_out), .out_valid(u_out_valid)
`ifdef PIPELINED_MAC_SATURATE_EN
        , .sat(u_sat)
`endif
    );

    // Count effective (ce=1, out of reset) edges; latency is measured in these.
    always @(posedge clk) begin
        last_en <= ce && rst_n;
        if (ce && rst_n) ce_cnt <= ce_cnt + 1;
    end

    // Monitors: a new result is presented only after an effective edge.
    always @(negedge clk) begin
        if (last_en && s_out_valid) begin
            cmp_cnt++;
            if (q_s.size() == 0) begin
                fail_cnt++;
                $display("FAIL s_unexpected: out=%h out_valid=1 at ce_cnt=%0d, no result pending", s_out, ce_cnt);
            end else begin
                exp_t e;
                e = q_s.pop_front();
                if (s_out !== e.val || ce_cnt != e.due
`ifdef PIPELINED_MAC_SATURATE_EN
                    || s_sat !== e.sat
`endif
                ) begin
                    fail_cnt++;
                    $display("FAIL s_result: got out=%h at ce_cnt=%0d, need out=%h sat=%b at ce_cnt=%0d",
                             s_out, ce_cnt, e.val, e.sat, e.due);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (last_en && u_out_valid) begin
            cmp_cnt++;
            if (q_u.size() == 0) begin
                fail_cnt++;
                $display("FAIL u_unexpected: out=%h out_valid=1 at ce_cnt=%0d, no result pending", u_out, ce_cnt);
            end else begin
                exp_t e;
                e = q_u.pop_front();
                if (u_out !== e.val || ce_cnt != e.due
`ifdef PIPELINED_MAC_SATURATE_EN
                    || u_sat !== e.sat
`endif
                ) begin
                    fail_cnt++;
                    $display("FAIL u_result: got out=%h at ce_cnt=%0d, need out=%h sat=%b at ce_cnt=%0d",
                             u_out, ce_cnt, e.val, e.sat, e.due);
                end
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %h, need %h", name, act, exp);
        end
    endtask

    // Present one input to the signed instance; accepted on the coming edge,
    // so its result is due PIPELINE_DEPTH-1 effective edges after that.
    task automatic issue_s(input logic [7:0] a, input logic [7:0] b, input logic ae,
                           input logic [7:0] ev, input logic es);
        exp_t e;
        @(negedge clk);
        s_in_valid = 1'b1; s_a = a; s_b = b; s_acc_en = ae;
        e.val = ev; e.sat = es; e.due = ce_cnt + 2;
        q_s.push_back(e);
    endtask

    task automatic issue_u(input logic [7:0] a, input logic [7:0] b, input logic ae,
                           input logic [7:0] ev, input logic es);
        exp_t e;
        @(negedge clk);
        u_in_valid = 1'b1; u_a = a; u_b = b; u_acc_en = ae;
        e.val = ev; e.sat = es; e.due = ce_cnt + 3;
        q_u.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        s_in_valid = 1'b0;
        u_in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q_s.size() != 0 || q_u.size() != 0) && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (q_s.size() != 0 || q_u.size() != 0) begin
            cmp_cnt++;
            fail_cnt++;
            $display("FAIL drain_timeout: %0d/%0d results still pending, need 0", q_s.size(), q_u.size());
            q_s.delete();
            q_u.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; ce = 1'b1;
        s_in_valid = 1'b0; s_a = '0; s_b = '0; s_acc_en = 1'b0;
        u_in_valid = 1'b0; u_a = '0; u_b = '0; u_acc_en = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_s_out", s_out, 8'h00);
        check("reset_s_valid", {7'd0, s_out_valid}, 8'h00);
        check("reset_u_valid", {7'd0, u_out_valid}, 8'h00);
`ifdef PIPELINED_MAC_SATURATE_EN
        check("reset_s_sat", {7'd0, s_sat}, 8'h00);
`endif
        rst_n = 1'b1;

        // -3 * 5 = -15
        issue_s(8'hFD, 8'd5, 1'b0, 8'hF1, 1'b0);
        idle();
        drain();

        // 6, then 6+20=26, then 26-6=20
        issue_s(8'd2, 8'd3, 1'b0, 8'd6, 1'b0);
        issue_s(8'd4, 8'd5, 1'b1, 8'd26, 1'b0);
        issue_s(8'hFF, 8'd6, 1'b1, 8'd20, 1'b0);
        idle();
        drain();

        // 100*100 = 0x2710: wraps to 0x10 or clamps to 0x7F
`ifdef PIPELINED_MAC_SATURATE_EN
        issue_s(8'd100, 8'd100, 1'b0, 8'h7F, 1'b1);
`else
        issue_s(8'd100, 8'd100, 1'b0, 8'h10, 1'b0);
`endif
        idle();
        drain();

        // Stall: accept, then three ce=0 edges with outputs frozen.
        hold = s_out;
        issue_s(8'd7, 8'd7, 1'b0, 8'h31, 1'b0);
        @(negedge clk);
        ce = 1'b0; s_in_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stall_valid_low", {7'd0, s_out_valid}, 8'h00);
            check("stall_out_held", s_out, hold);
        end
        ce = 1'b1;
        @(negedge clk);
        // Result now present; stall again and it must stay presented.
        ce = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("stall_valid_held", {7'd0, s_out_valid}, 8'h01);
            check("stall_result_held", s_out, 8'h31);
        end
        ce = 1'b1;
        drain();

        // Reset with an input in flight: load 10, then discard (3,3,1).
        issue_s(8'd10, 8'd1, 1'b0, 8'd10, 1'b0);
        idle();
        drain();
        @(negedge clk);
        s_in_valid = 1'b1; s_a = 8'd3; s_b = 8'd3; s_acc_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b0; s_in_valid = 1'b0;
        @(negedge clk);
        check("midrst_out", s_out, 8'h00);
        check("midrst_valid", {7'd0, s_out_valid}, 8'h00);
        rst_n = 1'b1;
        issue_s(8'd1, 8'd1, 1'b1, 8'd1, 1'b0);
        idle();
        drain();
        check("post_rst_quiet", {7'd0, s_out_valid}, 8'h00);

        // Unsigned depth-3: 255*2 = 0x1FE
`ifdef PIPELINED_MAC_SATURATE_EN
        issue_u(8'hFF, 8'd2, 1'b0, 8'hFF, 1'b1);
`else
        issue_u(8'hFF, 8'd2, 1'b0, 8'hFE, 1'b0);
`endif
        idle();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, need completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipelined_mac_param.md
Name: pipelined_mac_param

Overview:
- Parametrised successor to the fixed 8x8 two-stage signed multiply test design.
- Configurable operand/output width, pipeline depth and signedness.
- Adds a valid pipeline, a clock enable (stall) and a run-time accumulate mode.
- Serves as a Lakeroad DSP-template integration target: ECP5 MULT18X18C plus ALU54A accumulate path, behaviourally checkable in Verilator.

Parameters:
- A_WIDTH, 8: width of operand a.
- B_WIDTH, 8: width of operand b.
- OUT_WIDTH, 8: width of out; low bits of the accumulator.
- ACC_WIDTH, 24: internal accumulator width; must be >= A_WIDTH+B_WIDTH.
- PIPELINE_DEPTH, 2: cycles from accepted input to out; legal range 1..4.
- SIGNED, 1: 1 = two's-complement operands and sign-extended product; 0 = unsigned.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- ce  in  1  clock enable. 0 freezes every register, including out and out_valid.
- in_valid  in  1  a/b/acc_en are accepted on a cycle with ce=1 and in_valid=1.
- a  in  A_WIDTH  multiplicand.
- b  in  B_WIDTH  multiplier.
- acc_en  in  1  1 = add product to the accumulator; 0 = load the accumulator with the product.
- out  out  OUT_WIDTH  result: accumulator low bits (or saturated value, see feature).
- out_valid  out  1  result corresponding to one accepted input is present.

Behaviour:
- Reset: rst_n=0 at a clk edge clears all pipeline data, all valid bits, the accumulator, out and out_valid to 0. Reset overrides ce. Inputs presented during reset are dropped.
- Product: full A_WIDTH+B_WIDTH product, extended to ACC_WIDTH (sign-extended if SIGNED=1, else zero-extended). No intermediate truncation.
- Pipeline: PIPELINE_DEPTH register stages; the multiply is registered in stage 1.
  - The final stage updates the accumulator only when its valid bit is 1: acc <= acc_en ? acc + product : product. Addition wraps modulo 2^ACC_WIDTH.
  - acc_en travels with its operands.
  - A bubble (valid=0) leaves acc unchanged.
- Latency: an input accepted at ce-cycle t yields out/out_valid after the edge of ce-cycle t+PIPELINE_DEPTH-1, i.e. visible PIPELINE_DEPTH ce-cycles later. Cycles with ce=0 do not count.
- Throughput: one input per ce-cycle; back-to-back accumulation is exact with no hazards.
- out_valid = valid bit of the final stage. With ce=1 it is high for exactly one cycle per accepted input. With ce=0 it holds its value; downstream samples only when ce=1.
- out = acc[OUT_WIDTH-1:0] (wrap). out holds its last value when out_valid=0.
- Simultaneous events: reset beats ce and in_valid. ce=0 with in_valid=1 means the input is not accepted.
- Reset mid-operation: in-flight data is discarded; the next accumulation after reset starts from 0.

Optional Feature:
- Macro: PIPELINED_MAC_SATURATE_EN.
- Defined: out is acc clamped to the OUT_WIDTH range.
  - SIGNED=1: range [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - SIGNED=0: range [0, 2^OUT_WIDTH-1].
  - The accumulator itself still wraps internally.
  - Adds one port, sat (out, 1 bit): high in the same cycle out was clamped; reset to 0.
- Undefined: out wraps (low bits) and the sat port does not exist.

Test Plan:
- Defaults, ce=1: a=8'hFD (-3), b=5, acc_en=0 at cycle 0 -> out_valid=1, out=8'hF1 two cycles later; out_valid=0 the following cycle.
- Accumulate: (2,3,0),(4,5,1),(-1,6,1) back-to-back -> out = 6, 26, 20 on three consecutive cycles.
- Wrap vs saturate: a=100, b=100 (product 16'h2710) -> out=8'h10 without the macro; out=8'h7F, sat=1 with PIPELINED_MAC_SATURATE_EN.
- Stall: accept (7,7,0), drop ce for 3 cycles after the first edge -> out/out_valid frozen. out=8'h31 appears exactly 2 ce-cycles after acceptance, out_valid high one ce-cycle.
- Reset mid-flight: accumulate 10 into acc, then assert rst_n=0 one cycle with an input in stage 1 -> out=0, out_valid=0; next (1,1,1) yields out=1.
- SIGNED=0, PIPELINE_DEPTH=3: a=8'hFF, b=2 -> out=8'hFE three cycles after acceptance.
